// File: rtl/cordic_pkg.sv
// Shared constants, tag type and phase-wrap helper for the CORDIC channel scheduler.
// Phases are signed 1.2.13 fixed point, so +/-pi is +/-25736.
package cordic_pkg;

   localparam int PKG_PW         = 16;
   localparam int CORDIC_LAT_DEF = 20;
   localparam int TAG_CHW        = 4;

   localparam logic signed [15:0] PI_POS   = 16'sh6488;
   localparam logic signed [15:0] PI_NEG   = 16'sh9B78;
   localparam logic signed [17:0] PI_POS_X = 18'sd25736;
   localparam logic signed [17:0] PI_NEG_X = -18'sd25736;
   localparam logic signed [17:0] TWO_PI   = 18'sd51472;

   typedef struct packed {
      logic               valid;
      logic [TAG_CHW-1:0] ch;
   } tag_t;

   // Modular phase step; the result always lies in [PI_NEG, PI_POS).
   function automatic logic signed [15:0] phase_advance(input logic signed [15:0] ph,
                                                        input logic signed [15:0] inc);
      logic signed [17:0] s;
      logic signed [17:0] r;
      s = $signed({{2{ph[15]}}, ph}) + $signed({{2{inc[15]}}, inc});
      if (s >= PI_POS_X) begin
         r = s - TWO_PI;
      end else if (s < PI_NEG_X) begin
         r = s + TWO_PI;
      end else begin
         r = s;
      end
      return r[15:0];
   endfunction

endpackage

// File: rtl/cordic_channel_scheduler_rr_pick.sv
// Cyclic first-one search over the channel enable vector, starting at ptr.
module rr_pick
   import cordic_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = 2
) (
   input  logic [NCH-1:0] en,
   input  logic [CW-1:0]  ptr,
   output logic           found,
   output logic [CW-1:0]  idx
);

   logic [CW:0] pos_s;

   // Scan from farthest to nearest so the nearest enabled channel wins.
   always_comb begin
      found = 1'b0;
      idx   = ptr;
      pos_s = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         pos_s = {1'b0, ptr} + (CW+1)'(i);
         if (pos_s >= (CW+1)'(NCH)) begin
            pos_s = pos_s - (CW+1)'(NCH);
         end else begin
            pos_s = pos_s;
         end
         if (en[pos_s[CW-1:0]]) begin
            found = 1'b1;
            idx   = pos_s[CW-1:0];
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/cordic_channel_scheduler.sv
// Time-multiplexes one CORDIC core over NCH tone channels: round-robin phase issue,
// latency-matched tag line, per-channel sin/cos return and a sticky sync check.
module cordic_channel_scheduler
   import cordic_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int CW         = 2,
   parameter int PW         = PKG_PW,
   parameter int OW         = 16,
   parameter int CORDIC_LAT = CORDIC_LAT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [CW-1:0] cfg_ch,
   input  logic [PW-1:0] cfg_inc,
   input  logic          cfg_en,
   output logic          ph_tvalid,
   output logic [PW-1:0] ph_tdata,
   input  logic          dout_tvalid,
   input  logic [2*OW-1:0] dout_tdata,
   output logic          out_valid,
   output logic [CW-1:0] out_ch,
   output logic [OW-1:0] out_sin,
   output logic [OW-1:0] out_cos,
   output logic          sync_err
);

   localparam int MW = $clog2(CORDIC_LAT + 1);

   logic [NCH-1:0]       en_q, en_d;
   logic signed [PW-1:0] inc_q [NCH];
   logic signed [PW-1:0] inc_d [NCH];
   logic signed [PW-1:0] phase_q [NCH];
   logic signed [PW-1:0] phase_d [NCH];
   logic [CW-1:0]        ptr_q, ptr_d;
   logic                 ph_tvalid_q, ph_tvalid_d;
   logic [PW-1:0]        ph_tdata_q, ph_tdata_d;
   logic [CW-1:0]        ph_ch_q, ph_ch_d;
   tag_t                 tag_q [CORDIC_LAT];
   tag_t                 tag_d [CORDIC_LAT];
   tag_t                 tail_s;
   logic [MW-1:0]        mask_q, mask_d;
   logic                 out_valid_q, out_valid_d;
   logic [CW-1:0]        out_ch_q, out_ch_d;
   logic [OW-1:0]        out_sin_q, out_sin_d;
   logic [OW-1:0]        out_cos_q, out_cos_d;
   logic                 sync_err_q, sync_err_d;
   logic                 pick_found_s;
   logic [CW-1:0]        pick_idx_s;

   rr_pick #(.NCH(NCH), .CW(CW)) u_rr_pick (
      .en    (en_q),
      .ptr   (ptr_q),
      .found (pick_found_s),
      .idx   (pick_idx_s)
   );

   assign tail_s = tag_q[CORDIC_LAT-1];

   // Issue and config: the issue decision uses pre-write en/inc, so a write landing
   // on the issuing channel only takes effect from the following cycle.
   always_comb begin
      en_d        = en_q;
      ptr_d       = ptr_q;
      ph_tvalid_d = 1'b0;
      ph_tdata_d  = ph_tdata_q;
      ph_ch_d     = ph_ch_q;
      for (int c = 0; c < NCH; c++) begin
         inc_d[c]   = inc_q[c];
         phase_d[c] = phase_q[c];
      end
      if (pick_found_s) begin
         ph_tvalid_d         = 1'b1;
         ph_tdata_d          = phase_q[pick_idx_s];
         ph_ch_d             = pick_idx_s;
         ptr_d               = (pick_idx_s == CW'(NCH - 1)) ? '0 : pick_idx_s + CW'(1);
         phase_d[pick_idx_s] = phase_advance(phase_q[pick_idx_s], inc_q[pick_idx_s]);
      end else begin
         ph_tvalid_d = 1'b0;
      end
      if (cfg_we) begin
         inc_d[cfg_ch] = cfg_inc;
         en_d[cfg_ch]  = cfg_en;
         if (cfg_en && !en_q[cfg_ch]) begin
            phase_d[cfg_ch] = '0;
         end else begin
            phase_d[cfg_ch] = phase_d[cfg_ch];
         end
      end else begin
         en_d = en_d;
      end
   end

   // Tag line, output capture and masked sync check against the core's valid.
   always_comb begin
      tag_d[0] = '{valid: ph_tvalid_q, ch: TAG_CHW'(ph_ch_q)};
      for (int i = 1; i < CORDIC_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
      mask_d      = (mask_q != '0) ? mask_q - MW'(1) : mask_q;
      out_valid_d = tail_s.valid & dout_tvalid;
      out_ch_d    = out_ch_q;
      out_sin_d   = out_sin_q;
      out_cos_d   = out_cos_q;
      sync_err_d  = sync_err_q;
      if (out_valid_d) begin
         out_ch_d  = CW'(tail_s.ch);
         out_sin_d = dout_tdata[2*OW-1:OW];
         out_cos_d = dout_tdata[OW-1:0];
      end else begin
         out_ch_d = out_ch_q;
      end
      if ((mask_q == '0) && (tail_s.valid != dout_tvalid)) begin
         sync_err_d = 1'b1;
      end else begin
         sync_err_d = sync_err_q;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q        <= '0;
         ptr_q       <= '0;
         ph_tvalid_q <= 1'b0;
         ph_tdata_q  <= '0;
         ph_ch_q     <= '0;
         for (int c = 0; c < NCH; c++) begin
            inc_q[c]   <= '0;
            phase_q[c] <= '0;
         end
         for (int i = 0; i < CORDIC_LAT; i++) begin
            tag_q[i] <= '0;
         end
         mask_q      <= MW'(CORDIC_LAT);
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_sin_q   <= '0;
         out_cos_q   <= '0;
         sync_err_q  <= 1'b0;
      end else begin
         en_q        <= en_d;
         ptr_q       <= ptr_d;
         ph_tvalid_q <= ph_tvalid_d;
         ph_tdata_q  <= ph_tdata_d;
         ph_ch_q     <= ph_ch_d;
         for (int c = 0; c < NCH; c++) begin
            inc_q[c]   <= inc_d[c];
            phase_q[c] <= phase_d[c];
         end
         for (int i = 0; i < CORDIC_LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
         mask_q      <= mask_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_sin_q   <= out_sin_d;
         out_cos_q   <= out_cos_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign ph_tvalid = ph_tvalid_q;
   assign ph_tdata  = ph_tdata_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_sin   = out_sin_q;
   assign out_cos   = out_cos_q;
   assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_cordic_channel_scheduler.sv
// Directed bench: vector table for issue order/phase values, a latency-matched core model,
// and hand-written sequences for mid-run reset and sync-error injection.
module tb_cordic_channel_scheduler;

   localparam int LAT = 20;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_inc;
   logic        cfg_en;
   logic        ph_tvalid;
   logic [15:0] ph_tdata;
   logic        dout_tvalid;
   logic [31:0] dout_tdata;
   logic        out_valid;
   logic [1:0]  out_ch;
   logic [15:0] out_sin;
   logic [15:0] out_cos;
   logic        sync_err;

   cordic_channel_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_inc     (cfg_inc),
      .cfg_en      (cfg_en),
      .ph_tvalid   (ph_tvalid),
      .ph_tdata    (ph_tdata),
      .dout_tvalid (dout_tvalid),
      .dout_tdata  (dout_tdata),
      .out_valid   (out_valid),
      .out_ch      (out_ch),
      .out_sin     (out_sin),
      .out_cos     (out_cos),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: fixed LAT-cycle pipe, not reset, returns {phase, ~phase}.
   bit [LAT-1:0] pipe_v;
   bit [15:0]    pipe_d [LAT];
   bit           drop;
   always @(posedge clk) begin
      pipe_v[0] <= ph_tvalid;
      pipe_d[0] <= ph_tdata;
      for (int i = 1; i < LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
   end
   assign dout_tvalid = pipe_v[LAT-1] & ~drop;
   assign dout_tdata  = {pipe_d[LAT-1], ~pipe_d[LAT-1]};

   typedef struct {
      bit          we;
      bit [1:0]    ch;
      logic [15:0] inc;
      bit          en;
      bit          ev;
      bit [1:0]    ech;
      logic [15:0] ed;
   } vec_t;

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] d;
      int          cyc;
   } sb_t;

   vec_t vt [46];
   sb_t  sb_q [$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   sb_on = 1'b0;

   function automatic vec_t mk(bit we, bit [1:0] ch, logic [15:0] inc, bit en,
                               bit ev, bit [1:0] ech, logic [15:0] ed);
      vec_t v;
      v.we = we; v.ch = ch; v.inc = inc; v.en = en;
      v.ev = ev; v.ech = ech; v.ed = ed;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock and check any returned sample against the scoreboard.
   task automatic tick();
      sb_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (sb_on && out_valid) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: out_valid with no expected sample, ch %0d", out_ch);
         end else begin
            e = sb_q.pop_front();
            if (out_ch !== e.ch || out_sin !== e.d || out_cos !== ~e.d || (cyc - e.cyc) != LAT + 1) begin
               n_fail++;
               $display("FAIL sb_sample: got ch %0d sin %h cos %h lat %0d, expected ch %0d sin %h cos %h lat %0d",
                        out_ch, out_sin, out_cos, cyc - e.cyc, e.ch, e.d, ~e.d, LAT + 1);
            end
         end
      end
   endtask

   task automatic cfg(bit [1:0] ch, logic [15:0] inc, bit en);
      cfg_we = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_en = en;
      tick();
      cfg_we = 1'b0;
   endtask

   initial begin
      int n;
      int ov_cnt;
      int se_cnt;
      vt[0]  = mk(1, 0, 16'd256,  1, 0, 0, 16'd0);
      vt[1]  = mk(0, 0, 16'd0,    0, 1, 0, 16'd0);
      vt[2]  = mk(0, 0, 16'd0,    0, 1, 0, 16'd256);
      vt[3]  = mk(0, 0, 16'd0,    0, 1, 0, 16'd512);
      vt[4]  = mk(0, 0, 16'd0,    0, 1, 0, 16'd768);
      vt[5]  = mk(1, 0, 16'd1024, 1, 1, 0, 16'd1024);
      vt[6]  = mk(0, 0, 16'd0,    0, 1, 0, 16'd1280);
      vt[7]  = mk(0, 0, 16'd0,    0, 1, 0, 16'd2304);
      vt[8]  = mk(1, 0, 16'd1024, 0, 1, 0, 16'd3328);
      vt[9]  = mk(0, 0, 16'd0,    0, 0, 0, 16'd0);
      vt[10] = mk(1, 0, 16'd8192, 1, 0, 0, 16'd0);
      vt[11] = mk(0, 0, 16'd0,    0, 1, 0, 16'd0);
      vt[12] = mk(0, 0, 16'd0,    0, 1, 0, 16'd8192);
      vt[13] = mk(0, 0, 16'd0,    0, 1, 0, 16'd16384);
      vt[14] = mk(0, 0, 16'd0,    0, 1, 0, 16'd24576);
      vt[15] = mk(0, 0, 16'd0,    0, 1, 0, 16'hB6F0);
      vt[16] = mk(1, 0, 16'hE000, 0, 1, 0, 16'hD6F0);
      vt[17] = mk(1, 0, 16'hE000, 1, 0, 0, 16'd0);
      vt[18] = mk(0, 0, 16'd0,    0, 1, 0, 16'd0);
      vt[19] = mk(0, 0, 16'd0,    0, 1, 0, 16'hE000);
      vt[20] = mk(0, 0, 16'd0,    0, 1, 0, 16'hC000);
      vt[21] = mk(0, 0, 16'd0,    0, 1, 0, 16'hA000);
      vt[22] = mk(0, 0, 16'd0,    0, 1, 0, 16'h4910);
      vt[23] = mk(1, 0, 16'hE000, 0, 1, 0, 16'h2910);
      vt[24] = mk(0, 0, 16'd0,    0, 0, 0, 16'd0);
      vt[25] = mk(1, 0, 16'd64,   1, 0, 0, 16'd0);
      vt[26] = mk(1, 2, 16'd100,  1, 1, 0, 16'd0);
      vt[27] = mk(1, 3, 16'd200,  1, 1, 2, 16'd0);
      vt[28] = mk(0, 0, 16'd0,    0, 1, 3, 16'd0);
      vt[29] = mk(0, 0, 16'd0,    0, 1, 0, 16'd64);
      vt[30] = mk(0, 0, 16'd0,    0, 1, 2, 16'd100);
      vt[31] = mk(0, 0, 16'd0,    0, 1, 3, 16'd200);
      vt[32] = mk(0, 0, 16'd0,    0, 1, 0, 16'd128);
      vt[33] = mk(0, 0, 16'd0,    0, 1, 2, 16'd200);
      vt[34] = mk(1, 1, 16'd7,    1, 1, 3, 16'd400);
      vt[35] = mk(0, 0, 16'd0,    0, 1, 0, 16'd192);
      vt[36] = mk(0, 0, 16'd0,    0, 1, 1, 16'd0);
      vt[37] = mk(0, 0, 16'd0,    0, 1, 2, 16'd300);
      vt[38] = mk(0, 0, 16'd0,    0, 1, 3, 16'd600);
      vt[39] = mk(0, 0, 16'd0,    0, 1, 0, 16'd256);
      vt[40] = mk(0, 0, 16'd0,    0, 1, 1, 16'd7);
      vt[41] = mk(1, 0, 16'd64,   0, 1, 2, 16'd400);
      vt[42] = mk(1, 1, 16'd7,    0, 1, 3, 16'd800);
      vt[43] = mk(1, 2, 16'd100,  0, 1, 2, 16'd500);
      vt[44] = mk(1, 3, 16'd200,  0, 1, 3, 16'd1000);
      vt[45] = mk(0, 0, 16'd0,    0, 0, 0, 16'd0);

      rst = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_inc = 16'd0; cfg_en = 1'b0; drop = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ph_tvalid", 32'(ph_tvalid), 32'd0);
      chk("rst_ph_tdata",  32'(ph_tdata),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_ch",    32'(out_ch),    32'd0);
      chk("rst_out_sin",   32'(out_sin),   32'd0);
      chk("rst_out_cos",   32'(out_cos),   32'd0);
      chk("rst_sync_err",  32'(sync_err),  32'd0);

      sb_on = 1'b1;
      for (int i = 0; i < 46; i++) begin
         cfg_we = vt[i].we; cfg_ch = vt[i].ch; cfg_inc = vt[i].inc; cfg_en = vt[i].en;
         tick();
         chk($sformatf("vec%0d_tvalid", i), 32'(ph_tvalid), 32'(vt[i].ev));
         if (vt[i].ev) begin
            chk($sformatf("vec%0d_tdata", i), 32'(ph_tdata), 32'(vt[i].ed));
            sb_q.push_back('{ch: vt[i].ech, d: vt[i].ed, cyc: cyc});
         end
      end
      cfg_we = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("table_sync_err", 32'(sync_err), 32'd0);
      sb_on = 1'b0;

      // Mid-run reset with samples still inside the core.
      cfg(2'd0, 16'd256, 1'b1);
      cfg(2'd2, 16'd512, 1'b1);
      for (int i = 0; i < 8; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_ph_tvalid", 32'(ph_tvalid), 32'd0);
      ov_cnt = 0;
      se_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (out_valid) ov_cnt++;
         if (sync_err) se_cnt++;
      end
      chk("mrst_out_valid_cycles", 32'(ov_cnt), 32'd0);
      chk("mrst_sync_err_cycles",  32'(se_cnt), 32'd0);

      // Restart: ch0 then ch2; first issue is ch0 from phase 0.
      cfg(2'd0, 16'd256, 1'b1);
      chk("rs_idle_tvalid", 32'(ph_tvalid), 32'd0);
      cfg(2'd2, 16'd100, 1'b1);
      chk("rs_first_tvalid", 32'(ph_tvalid), 32'd1);
      chk("rs_first_tdata",  32'(ph_tdata),  32'd0);
      tick();
      chk("rs_ch2_tdata", 32'(ph_tdata), 32'd0);
      tick();
      chk("rs_ch0_tdata2", 32'(ph_tdata), 32'd256);
      n = 2;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("latency", 32'(n), 32'(LAT + 1));
      chk("lat_out_ch",  32'(out_ch),  32'd0);
      chk("lat_out_sin", 32'(out_sin), 32'd0);
      chk("lat_out_cos", 32'(out_cos), 32'hFFFF);
      tick();
      chk("lat2_out_ch",  32'(out_ch),  32'd2);
      chk("lat2_out_sin", 32'(out_sin), 32'd0);

      // Drop one core valid pulse after the mask has expired.
      chk("pre_drop_sync_err", 32'(sync_err), 32'd0);
      drop = 1'b1;
      tick();
      drop = 1'b0;
      chk("drop_sync_err",  32'(sync_err),  32'd1);
      chk("drop_out_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("sticky_sync_err", 32'(sync_err), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("clr_sync_err", 32'(sync_err), 32'd0);
      se_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (sync_err) se_cnt++;
      end
      chk("post_rst_sync_err_cycles", 32'(se_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
